obi_mux_n_to_1: RTL and testbench

- Parametrised N-initiator to 1-target OBI interconnect. Successor to the fixed 2:1 priority mux.
- Adds a configurable initiator count and selectable fixed-priority or round-robin arbitration.
- Keeps address-phase lock until grant, and allows multiple outstanding transactions tracked by an in-order ID FIFO.
- Sits between core/DMA/debug initiators and a single shared SRAM or peripheral bus target.

---
 rtl/obi_pkg.sv | 24 ++
 rtl/obi_id_fifo.sv | 63 ++++++
 rtl/obi_mux_n_to_1.sv | 168 ++++++++++++++++
 tb/tb_obi_mux_n_to_1.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_pkg.sv
// Shared OBI field widths and arbitration-mode encodings for the OBI interconnect.
package obi_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Address-phase payload that travels with the selected request.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } obi_req_t;

    // Width of an initiator index; a single initiator still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// In-order FIFO of initiator IDs used to route responses back to their requester.
module obi_id_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [W-1:0]     push_id,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/obi_mux_n_to_1.sv
// N-initiator to 1-target OBI interconnect with fixed or round-robin arbitration,
// address-phase lock until grant and in-order response routing.
module obi_mux_n_to_1
    import obi_pkg::*;
#(
    parameter int NUM_INIT        = 2,
    parameter int ARB_MODE        = 0,
    parameter int MAX_OUTSTANDING = 2,
    parameter int WRITE_RESP      = 0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_INIT-1:0]                  init_req_i,
    output logic [NUM_INIT-1:0]                  init_gnt_o,
    input  logic [NUM_INIT*ADDR_W-1:0]           init_addr_i,
    input  logic [NUM_INIT-1:0]                  init_we_i,
    input  logic [NUM_INIT*BE_W-1:0]             init_be_i,
    input  logic [NUM_INIT*DATA_W-1:0]           init_wdata_i,
    output logic [NUM_INIT-1:0]                  init_rvalid_o,
    output logic [NUM_INIT*DATA_W-1:0]           init_rdata_o,
    output logic                                 shr_req_o,
    input  logic                                 shr_gnt_i,
    output logic [ADDR_W-1:0]                    shr_addr_o,
    output logic                                 shr_we_o,
    output logic [BE_W-1:0]                      shr_be_o,
    output logic [DATA_W-1:0]                    shr_wdata_o,
    input  logic                                 shr_rvalid_i,
    input  logic [DATA_W-1:0]                    shr_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 resp_err_o
);

    localparam int ID_W  = id_width(NUM_INIT);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // Handshake: an address phase completes when shr_req_o and the selected
    // init_gnt_o are both high in the same cycle; rvalid has no back-pressure.

    logic                  lock_q;
    logic [ID_W-1:0]       lock_id_q;
    // Holds the index where the next round-robin search starts (last winner + 1).
    logic [ID_W-1:0]       rr_ptr_q;
    logic                  err_q;

    logic [2*NUM_INIT-1:0] req_rot;
    logic [ID_W:0]         rr_sum;
    logic                  arb_found;
    logic [ID_W-1:0]       arb_sel;
    logic [ID_W-1:0]       sel;
    obi_req_t              sel_req;

    logic                  room;
    logic                  handshake;
    logic                  fifo_push;
    logic [ID_W-1:0]       fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        rr_sum    = '0;
        req_rot   = {init_req_i, init_req_i} >> rr_ptr_q;
        if (ARB_MODE == ARB_RR) begin
            for (int k = 0; k < NUM_INIT; k++) begin
                if (!arb_found && req_rot[k]) begin
                    arb_found = 1'b1;
                    rr_sum    = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
                    if (rr_sum >= (ID_W + 1)'(NUM_INIT)) begin
                        rr_sum = rr_sum - (ID_W + 1)'(NUM_INIT);
                    end
                    arb_sel = rr_sum[ID_W-1:0];
                end
            end
        end else begin
            for (int k = 0; k < NUM_INIT; k++) begin
                if (!arb_found && init_req_i[k]) begin
                    arb_found = 1'b1;
                    arb_sel   = ID_W'(k);
                end
            end
        end
    end

    // A pending, ungranted request keeps the mux pinned to its initiator.
    assign sel = lock_q ? lock_id_q : arb_sel;

    always_comb begin
        shr_req_o = 1'b0;
        sel_req   = '0;
        for (int k = 0; k < NUM_INIT; k++) begin
            if (sel == ID_W'(k)) begin
                shr_req_o     = init_req_i[k];
                sel_req.addr  = init_addr_i[ADDR_W*k +: ADDR_W];
                sel_req.we    = init_we_i[k];
                sel_req.be    = init_be_i[BE_W*k +: BE_W];
                sel_req.wdata = init_wdata_i[DATA_W*k +: DATA_W];
            end
        end
    end

    assign shr_addr_o  = sel_req.addr;
    assign shr_we_o    = sel_req.we;
    assign shr_be_o    = sel_req.be;
    assign shr_wdata_o = sel_req.wdata;

    assign room      = ~fifo_full | shr_rvalid_i;
    assign handshake = shr_req_o & shr_gnt_i & room;
    assign fifo_push = handshake & (~shr_we_o | (WRITE_RESP != 0));

    always_comb begin
        init_gnt_o    = '0;
        init_rvalid_o = '0;
        init_rdata_o  = '0;
        for (int k = 0; k < NUM_INIT; k++) begin
            if (sel == ID_W'(k)) begin
                init_gnt_o[k] = handshake;
            end
            if (shr_rvalid_i && !fifo_empty && fifo_head == ID_W'(k)) begin
                init_rvalid_o[k]                   = 1'b1;
                init_rdata_o[DATA_W*k +: DATA_W]   = shr_rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            if (shr_req_o && !handshake) begin
                lock_q    <= 1'b1;
                lock_id_q <= sel;
            end else begin
                lock_q    <= 1'b0;
            end
            if (handshake) begin
                rr_ptr_q <= (sel == ID_W'(NUM_INIT - 1)) ? '0 : sel + 1'b1;
            end
            if (shr_rvalid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (ID_W),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (fifo_push),
        .push_id (sel),
        .pop     (shr_rvalid_i),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign outstanding_o = fifo_count;
    assign resp_err_o    = err_q;

endmodule

// File: tb/tb_obi_mux_n_to_1.sv
// Directed bench for obi_mux_n_to_1: a fixed-priority and a round-robin instance
// share the same initiator/target stimulus.
module tb_obi_mux_n_to_1;

    localparam int N = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [N-1:0]  req;
    logic [N*32-1:0] addr;
    logic [N-1:0]  we;
    logic [N*4-1:0] be;
    logic [N*32-1:0] wdata;
    logic          shr_gnt;
    logic          shr_rvalid;
    logic [31:0]   shr_rdata;

    logic [N-1:0]    f_gnt, r_gnt;
    logic [N-1:0]    f_rvalid, r_rvalid;
    logic [N*32-1:0] f_rdata, r_rdata;
    logic            f_shr_req, r_shr_req;
    logic [31:0]     f_shr_addr, r_shr_addr;
    logic            f_shr_we, r_shr_we;
    logic [3:0]      f_shr_be, r_shr_be;
    logic [31:0]     f_shr_wdata, r_shr_wdata;
    logic [1:0]      f_out, r_out;
    logic            f_err, r_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_id;

    localparam logic [2:0] RR_EXP [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    always #5 clk_i = ~clk_i;

    obi_mux_n_to_1 #(.NUM_INIT(N), .ARB_MODE(0), .MAX_OUTSTANDING(2), .WRITE_RESP(0)) dut_fix (
        .clk_i(clk_i), .rst_i(rst_i),
        .init_req_i(req), .init_gnt_o(f_gnt), .init_addr_i(addr), .init_we_i(we),
        .init_be_i(be), .init_wdata_i(wdata), .init_rvalid_o(f_rvalid), .init_rdata_o(f_rdata),
        .shr_req_o(f_shr_req), .shr_gnt_i(shr_gnt), .shr_addr_o(f_shr_addr), .shr_we_o(f_shr_we),
        .shr_be_o(f_shr_be), .shr_wdata_o(f_shr_wdata), .shr_rvalid_i(shr_rvalid),
        .shr_rdata_i(shr_rdata), .outstanding_o(f_out), .resp_err_o(f_err)
    );

    obi_mux_n_to_1 #(.NUM_INIT(N), .ARB_MODE(1), .MAX_OUTSTANDING(2), .WRITE_RESP(0)) dut_rr (
        .clk_i(clk_i), .rst_i(rst_i),
        .init_req_i(req), .init_gnt_o(r_gnt), .init_addr_i(addr), .init_we_i(we),
        .init_be_i(be), .init_wdata_i(wdata), .init_rvalid_o(r_rvalid), .init_rdata_o(r_rdata),
        .shr_req_o(r_shr_req), .shr_gnt_i(shr_gnt), .shr_addr_o(r_shr_addr), .shr_we_o(r_shr_we),
        .shr_be_o(r_shr_be), .shr_wdata_o(r_shr_wdata), .shr_rvalid_i(shr_rvalid),
        .shr_rdata_i(shr_rdata), .outstanding_o(r_out), .resp_err_o(r_err)
    );

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] w, input logic g,
                         input logic rv, input logic [31:0] rd);
        req        = r;
        we         = w;
        shr_gnt    = g;
        shr_rvalid = rv;
        shr_rdata  = rd;
    endtask

    task automatic set_addr(input int k, input logic [31:0] a);
        addr[32*k +: 32] = a;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive('0, '0, 1'b0, 1'b0, '0);
        adv();
        adv();
        rst_i = 1'b0;
    endtask

    initial begin
        addr  = '0;
        wdata = '0;
        be    = {4'hC, 4'h3, 4'hF};
        do_reset();

        // Reset state; target grant alone must not produce an initiator grant.
        drive('0, '0, 1'b1, 1'b0, '0);
        sample();
        check_eq("rst_gnt", f_gnt, 3'b000);
        check_eq("rst_rvalid", f_rvalid, 3'b000);
        check_eq("rst_rdata", f_rdata, 96'h0);
        check_eq("rst_out", f_out, 2'd0);
        check_eq("rst_err", f_err, 1'b0);
        check_eq("rst_shr_req", f_shr_req, 1'b0);

        // Fixed priority with in-order response routing.
        adv();
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        set_addr(0, 32'h10);
        set_addr(2, 32'h20);
        drive(3'b101, 3'b000, 1'b1, 1'b0, '0);
        sample();
        check_eq("t1_c0_gnt", f_gnt, 3'b001);
        check_eq("t1_c0_addr", f_shr_addr, 32'h10);
        check_eq("t1_c0_req", f_shr_req, 1'b1);
        adv();
        drive(3'b100, 3'b000, 1'b1, 1'b0, '0);
        sample();
        check_eq("t1_c1_gnt", f_gnt, 3'b100);
        check_eq("t1_c1_addr", f_shr_addr, 32'h20);
        check_eq("t1_c1_out", f_out, 2'd1);
        adv();
        drive(3'b000, 3'b000, 1'b1, 1'b1, 32'hA5A5_0000);
        sample();
        exp_id = exp_q.pop_front();
        check_eq("t1_r0_rvalid", f_rvalid, 3'b001 << exp_id);
        check_eq("t1_r0_rdata", f_rdata, 96'hA5A5_0000);
        check_eq("t1_r0_out", f_out, 2'd2);
        adv();
        drive(3'b000, 3'b000, 1'b1, 1'b1, 32'h5A5A_1111);
        sample();
        exp_id = exp_q.pop_front();
        check_eq("t1_r1_rvalid", f_rvalid, 3'b001 << exp_id);
        check_eq("t1_r1_rdata", f_rdata, {32'h5A5A_1111, 64'h0});
        check_eq("t1_r1_out", f_out, 2'd1);
        adv();
        drive(3'b000, 3'b000, 1'b0, 1'b0, '0);
        sample();
        check_eq("t1_end_out", f_out, 2'd0);
        check_eq("t1_end_rvalid", f_rvalid, 3'b000);

        // Round-robin over continuous untracked writes; fixed instance keeps picking 0.
        do_reset();
        drive(3'b111, 3'b111, 1'b1, 1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            sample();
            check_eq($sformatf("rr_gnt_%0d", i), r_gnt, RR_EXP[i]);
            check_eq($sformatf("fix_gnt_%0d", i), f_gnt, 3'b001);
            adv();
        end
        drive(3'b000, 3'b000, 1'b0, 1'b0, '0);
        sample();
        check_eq("rr_out", r_out, 2'd0);

        // Address-phase lock while the target withholds grant.
        do_reset();
        set_addr(1, 32'h100);
        set_addr(0, 32'h200);
        drive(3'b010, 3'b000, 1'b0, 1'b0, '0);
        sample();
        check_eq("lk_c0_addr", f_shr_addr, 32'h100);
        check_eq("lk_c0_gnt", f_gnt, 3'b000);
        for (int i = 1; i < 3; i++) begin
            adv();
            drive(3'b011, 3'b000, 1'b0, 1'b0, '0);
            sample();
            check_eq($sformatf("lk_c%0d_addr", i), f_shr_addr, 32'h100);
            check_eq($sformatf("lk_c%0d_gnt", i), f_gnt, 3'b000);
        end
        adv();
        drive(3'b011, 3'b000, 1'b1, 1'b0, '0);
        sample();
        check_eq("lk_c3_gnt", f_gnt, 3'b010);
        check_eq("lk_c3_addr", f_shr_addr, 32'h100);
        adv();
        drive(3'b001, 3'b000, 1'b1, 1'b0, '0);
        sample();
        check_eq("lk_c4_gnt", f_gnt, 3'b001);
        check_eq("lk_c4_addr", f_shr_addr, 32'h200);
        adv();
        drive(3'b000, 3'b000, 1'b0, 1'b1, 32'h11);
        sample();
        check_eq("lk_r0_out", f_out, 2'd2);
        check_eq("lk_r0_rvalid", f_rvalid, 3'b010);
        adv();
        drive(3'b000, 3'b000, 1'b0, 1'b1, 32'h22);
        sample();
        check_eq("lk_r1_rvalid", f_rvalid, 3'b001);
        check_eq("lk_r1_rdata", f_rdata, 96'h22);

        // Full ID FIFO stalls the third read until a response frees a slot.
        do_reset();
        set_addr(0, 32'h30);
        set_addr(1, 32'h40);
        set_addr(2, 32'h50);
        drive(3'b001, 3'b000, 1'b1, 1'b0, '0);
        sample();
        check_eq("fu_c0_gnt", f_gnt, 3'b001);
        adv();
        drive(3'b010, 3'b000, 1'b1, 1'b0, '0);
        sample();
        check_eq("fu_c1_gnt", f_gnt, 3'b010);
        check_eq("fu_c1_out", f_out, 2'd1);
        adv();
        drive(3'b100, 3'b000, 1'b1, 1'b0, '0);
        sample();
        check_eq("fu_c2_gnt", f_gnt, 3'b000);
        check_eq("fu_c2_out", f_out, 2'd2);
        check_eq("fu_c2_addr", f_shr_addr, 32'h50);
        adv();
        drive(3'b100, 3'b000, 1'b1, 1'b1, 32'h1234);
        sample();
        check_eq("fu_c3_gnt", f_gnt, 3'b100);
        check_eq("fu_c3_rvalid", f_rvalid, 3'b001);
        check_eq("fu_c3_out", f_out, 2'd2);
        adv();
        drive(3'b000, 3'b000, 1'b0, 1'b0, '0);
        sample();
        check_eq("fu_c4_out", f_out, 2'd2);

        // Untracked write followed by a tracked read.
        do_reset();
        set_addr(1, 32'h60);
        set_addr(2, 32'h70);
        wdata[32 +: 32] = 32'hDEAD_BEEF;
        drive(3'b010, 3'b010, 1'b1, 1'b0, '0);
        sample();
        check_eq("wr_gnt", f_gnt, 3'b010);
        check_eq("wr_we", f_shr_we, 1'b1);
        check_eq("wr_wdata", f_shr_wdata, 32'hDEAD_BEEF);
        check_eq("wr_be", f_shr_be, 4'h3);
        adv();
        drive(3'b100, 3'b000, 1'b1, 1'b0, '0);
        sample();
        check_eq("wr_out0", f_out, 2'd0);
        check_eq("rd_gnt", f_gnt, 3'b100);
        check_eq("rd_we", f_shr_we, 1'b0);
        adv();
        drive(3'b000, 3'b000, 1'b0, 1'b1, 32'hCAFE_0001);
        sample();
        check_eq("rd_rvalid", f_rvalid, 3'b100);
        check_eq("rd_rdata", f_rdata, {32'hCAFE_0001, 64'h0});
        check_eq("rd_out1", f_out, 2'd1);
        adv();
        drive(3'b000, 3'b000, 1'b0, 1'b0, '0);
        sample();
        check_eq("rd_out0", f_out, 2'd0);

        // Response with nothing outstanding raises the sticky error.
        adv();
        drive(3'b000, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF);
        sample();
        check_eq("er_rvalid", f_rvalid, 3'b000);
        check_eq("er_rdata", f_rdata, 96'h0);
        check_eq("er_pre", f_err, 1'b0);
        adv();
        drive(3'b000, 3'b000, 1'b0, 1'b0, '0);
        sample();
        check_eq("er_set", f_err, 1'b1);
        adv();
        sample();
        check_eq("er_sticky", f_err, 1'b1);
        do_reset();
        sample();
        check_eq("er_clr", f_err, 1'b0);
        check_eq("er_out", f_out, 2'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
